// File: rtl/pkt_tx_scheduler_if.sv
// AXI-Stream bundle between the transmit scheduler, its two payload sources
// and the packetizer input FIFO. The master side is the scheduler.
interface pkt_tx_scheduler_if #(
  parameter int BYTES = 1
);
  logic [BYTES*8-1:0] S0_tdata;
  logic               S0_tvalid;
  logic               S0_tready;
  logic [BYTES*8-1:0] S1_tdata;
  logic               S1_tvalid;
  logic               S1_tready;
  logic [BYTES*8-1:0] M_tdata;
  logic               M_tvalid;
  logic               M_tready;
  logic               M_tlast;
  logic               M_tuser;

  modport master (
    input  S0_tdata, S0_tvalid, S1_tdata, S1_tvalid, M_tready,
    output S0_tready, S1_tready, M_tdata, M_tvalid, M_tlast, M_tuser
  );

  modport slave (
    output S0_tdata, S0_tvalid, S1_tdata, S1_tvalid, M_tready,
    input  S0_tready, S1_tready, M_tdata, M_tvalid, M_tlast, M_tuser
  );
endinterface

// File: rtl/pkt_tx_scheduler.sv
// Round-robin transmit scheduler: grants one of two payload sources, streams
// its symbols to the packetizer FIFO with tlast/tuser, waits for pkt_sent and
// then holds an idle gap so packets never overlap in the FIFO.
module pkt_tx_scheduler #(
  parameter int BYTES        = 1,
  parameter int GAP_CYCLES   = 16,
  parameter int SENT_TIMEOUT = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req,
  input  logic [15:0]               len0,
  input  logic [15:0]               len1,
  input  logic [1:0]                bpsk,
  pkt_tx_scheduler_if.master        axis,
  output logic [15:0]               payload_length,
  input  logic                      pkt_sent,
  output logic [1:0]                gnt,
  output logic                      done,
  output logic                      err,
  output logic                      busy
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_SENT = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(SENT_TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        ptr_q, ptr_d;        // source preferred when both request
  logic        sel_q, sel_d;        // source of the current packet
  logic [1:0]  gnt_q, gnt_d;
  logic [15:0] len_q, len_d;
  logic        bpsk_q, bpsk_d;
  logic [15:0] sym_q, sym_d;
  logic [15:0] cnt_q, cnt_d;        // symbol / timeout / gap counter
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        pkt_sent_q;

  logic               load;
  logic               sel_tvalid;
  logic [BYTES*8-1:0] sel_tdata;
  logic               m_fire;
  logic               last_sym;
  logic               sent_rise;

  assign load       = (state_q == ST_LOAD);
  assign sel_tvalid = sel_q ? axis.S1_tvalid : axis.S0_tvalid;
  assign sel_tdata  = sel_q ? axis.S1_tdata  : axis.S0_tdata;
  assign last_sym   = (cnt_q == sym_q - 16'd1);
  assign m_fire     = load & sel_tvalid & axis.M_tready;
  assign sent_rise  = pkt_sent & ~pkt_sent_q;

  // Pass-through of the granted source; everything is gated off outside LOAD
  // so a reset or state change drops valid/ready/tlast without a clock edge.
  assign axis.M_tvalid  = load & sel_tvalid;
  assign axis.M_tdata   = load ? sel_tdata : '0;
  assign axis.M_tlast   = load & last_sym;
  assign axis.M_tuser   = bpsk_q;
  assign axis.S0_tready = load & ~sel_q & axis.M_tready;
  assign axis.S1_tready = load &  sel_q & axis.M_tready;

  assign payload_length = len_q;
  assign gnt            = gnt_q;
  assign done           = done_q;
  assign err            = err_q;
  assign busy           = (state_q != ST_IDLE);

  // Next-state logic: arbitration, symbol counting, pkt_sent wait and gap.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    len_d   = len_q;
    bpsk_d  = bpsk_q;
    sym_d   = sym_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          sel_d  = (req == 2'b11) ? ptr_q : req[1];
          len_d  = sel_d ? len1 : len0;
          bpsk_d = sel_d ? bpsk[1] : bpsk[0];
          // QPSK carries two bits per symbol; an odd trailing bit is dropped.
          sym_d  = bpsk_d ? len_d : {1'b0, len_d[15:1]};
          cnt_d  = '0;
          if (sym_d == 16'd0) begin
            err_d = 1'b1;
            ptr_d = ~sel_d;
          end else begin
            gnt_d   = sel_d ? 2'b10 : 2'b01;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (m_fire) begin
          if (last_sym) begin
            cnt_d   = '0;
            gnt_d   = 2'b00;
            state_d = ST_WAIT_SENT;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ST_WAIT_SENT: begin
        if (sent_rise) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_GAP;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          ptr_d   = ~sel_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b0;
      sel_q      <= 1'b0;
      gnt_q      <= 2'b00;
      len_q      <= '0;
      bpsk_q     <= 1'b0;
      sym_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pkt_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      len_q      <= len_d;
      bpsk_q     <= bpsk_d;
      sym_q      <= sym_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pkt_sent_q <= pkt_sent;
    end
  end

endmodule

// File: tb/tb_pkt_tx_scheduler.sv
// Self-checking bench for pkt_tx_scheduler: table-driven packets plus directed
// round-robin, backpressure, timeout and mid-packet reset sequences.
module tb_pkt_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] len0 = '0;
  logic [15:0] len1 = '0;
  logic [1:0]  bpsk = 2'b00;
  logic        pkt_sent = 1'b0;
  logic [15:0] payload_length;
  logic [1:0]  gnt;
  logic        done;
  logic        err;
  logic        busy;

  int total  = 0;
  int passed = 0;

  pkt_tx_scheduler_if #(.BYTES(1)) axis ();

  pkt_tx_scheduler #(
    .BYTES(1),
    .GAP_CYCLES(16),
    .SENT_TIMEOUT(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .len0(len0),
    .len1(len1),
    .bpsk(bpsk),
    .axis(axis),
    .payload_length(payload_length),
    .pkt_sent(pkt_sent),
    .gnt(gnt),
    .done(done),
    .err(err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [15:0] len0;
    logic [15:0] len1;
    logic [1:0]  bpsk;
    bit          pre_high;
    int          exp_src;
    int          exp_sym;
    logic        exp_user;
    logic [15:0] exp_plen;
    bit          exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one granted packet from IDLE through GAP back to IDLE.
  task automatic do_packet(input string name, input logic [1:0] r, input int exp_src,
                           input int exp_sym, input logic exp_user, input logic [15:0] exp_plen,
                           input bit rand_bp, input bit pre_high, input bit no_sent);
    int   xfers = 0;
    int   cyc = 0;
    int   steps = 0;
    bit   order_ok = 1, user_ok = 1, last_ok = 1, bad_rdy = 0, fire, gap_ok = 1, saw_done = 0;
    logic [7:0] exp_data;
    exp_data = (exp_src == 0) ? axis.S0_tdata : axis.S1_tdata;
    req = r;
    if (pre_high) pkt_sent = 1'b1;
    step();
    check({name, " gnt"}, 32'(gnt), (exp_src == 0) ? 32'd1 : 32'd2);
    check({name, " busy"}, 32'(busy), 32'd1);
    check({name, " payload_length"}, 32'(payload_length), 32'(exp_plen));
    req = 2'b00;
    while (xfers < exp_sym && cyc < 1000) begin
      if (rand_bp) begin
        axis.M_tready  = 1'($urandom_range(0, 1));
        axis.S0_tvalid = 1'($urandom_range(0, 1));
        axis.S1_tvalid = 1'($urandom_range(0, 1));
      end
      #1;
      if ((exp_src == 0 && axis.S1_tready) || (exp_src == 1 && axis.S0_tready)) bad_rdy = 1;
      if (axis.M_tvalid && (axis.M_tlast !== (xfers == exp_sym - 1))) last_ok = 0;
      fire = axis.M_tvalid && axis.M_tready;
      if (fire) begin
        if (axis.M_tdata !== exp_data) order_ok = 0;
        if (axis.M_tuser !== exp_user) user_ok = 0;
        exp_data++;
        xfers++;
      end
      step();
      if (fire) begin
        if (exp_src == 0) axis.S0_tdata++;
        else axis.S1_tdata++;
      end
      cyc++;
    end
    axis.M_tready  = 1'b1;
    axis.S0_tvalid = 1'b1;
    axis.S1_tvalid = 1'b1;
    #1;
    check({name, " transfers"}, 32'(xfers), 32'(exp_sym));
    check({name, " data order"}, 32'(order_ok), 32'd1);
    check({name, " tuser"}, 32'(user_ok), 32'd1);
    check({name, " tlast position"}, 32'(last_ok), 32'd1);
    check({name, " unselected tready"}, 32'(bad_rdy), 32'd0);
    check({name, " gnt after last"}, 32'(gnt), 32'd0);
    check({name, " tvalid in wait"}, 32'(axis.M_tvalid), 32'd0);

    if (no_sent) begin
      while (!err && steps < 200) begin
        step();
        steps++;
      end
      check({name, " timeout cycles"}, 32'(steps), 32'd100);
      check({name, " no done on timeout"}, 32'(done), 32'd0);
    end else begin
      if (pre_high) begin
        for (int i = 0; i < 3; i++) begin
          step();
          if (done) saw_done = 1;
        end
        check({name, " stale pkt_sent ignored"}, 32'(saw_done), 32'd0);
        pkt_sent = 1'b0;
      end
      step();
      pkt_sent = 1'b1;
      step();
      check({name, " done pulse"}, 32'(done), 32'd1);
      check({name, " err quiet"}, 32'(err), 32'd0);
    end
    pkt_sent = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (!busy || done || err) gap_ok = 0;
    end
    check({name, " gap busy"}, 32'(gap_ok), 32'd1);
    step();
    check({name, " idle after gap"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // {req, len0, len1, bpsk, pre_high, src, sym, tuser, plen, err}
    vecs[0] = '{2'b01, 16'd8, 16'd0, 2'b01, 1'b0, 0, 8, 1'b1, 16'd8, 1'b0};
    vecs[1] = '{2'b10, 16'd0, 16'd7, 2'b00, 1'b0, 1, 3, 1'b0, 16'd7, 1'b0};
    vecs[2] = '{2'b01, 16'd1, 16'd0, 2'b00, 1'b0, 0, 0, 1'b0, 16'd1, 1'b1};
    vecs[3] = '{2'b10, 16'd0, 16'd5, 2'b10, 1'b0, 1, 5, 1'b1, 16'd5, 1'b0};
    vecs[4] = '{2'b01, 16'd2, 16'd0, 2'b00, 1'b1, 0, 1, 1'b0, 16'd2, 1'b0};

    axis.S0_tdata  = 8'h00;
    axis.S1_tdata  = 8'h80;
    axis.S0_tvalid = 1'b1;
    axis.S1_tvalid = 1'b1;
    axis.M_tready  = 1'b1;

    #3;
    check("reset gnt", 32'(gnt), 32'd0);
    check("reset payload_length", 32'(payload_length), 32'd0);
    check("reset done/err/busy", {29'd0, done, err, busy}, 32'd0);
    check("reset M_tvalid/M_tlast", {30'd0, axis.M_tvalid, axis.M_tlast}, 32'd0);
    check("reset S tready", {30'd0, axis.S0_tready, axis.S1_tready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 5; v++) begin
      len0 = vecs[v].len0;
      len1 = vecs[v].len1;
      bpsk = vecs[v].bpsk;
      if (vecs[v].exp_err) begin
        req = vecs[v].req;
        step();
        check($sformatf("vec%0d err pulse", v), 32'(err), 32'd1);
        check($sformatf("vec%0d gnt stays 0", v), 32'(gnt), 32'd0);
        check($sformatf("vec%0d stays idle", v), {30'd0, busy, axis.M_tvalid}, 32'd0);
        req = 2'b00;
        step();
        check($sformatf("vec%0d err one cycle", v), {30'd0, err, busy}, 32'd0);
      end else begin
        do_packet($sformatf("vec%0d", v), vecs[v].req, vecs[v].exp_src, vecs[v].exp_sym,
                  vecs[v].exp_user, vecs[v].exp_plen, 1'b0, vecs[v].pre_high, 1'b0);
      end
    end

    // Random source/sink backpressure, 20 BPSK symbols from source 0.
    len0 = 16'd20;
    bpsk = 2'b01;
    do_packet("backpressure", 2'b01, 0, 20, 1'b1, 16'd20, 1'b1, 1'b0, 1'b0);

    // pkt_sent never rises: timeout error, then gap, then idle.
    len1 = 16'd9;
    bpsk = 2'b10;
    do_packet("timeout", 2'b10, 1, 9, 1'b1, 16'd9, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of LOAD.
    len0 = 16'd20;
    bpsk = 2'b01;
    req  = 2'b01;
    step();
    check("midload gnt before reset", 32'(gnt), 32'd1);
    req = 2'b00;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midload reset M_tvalid", 32'(axis.M_tvalid), 32'd0);
    check("midload reset gnt", 32'(gnt), 32'd0);
    check("midload reset busy/tlast", {30'd0, busy, axis.M_tlast}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Both sources requesting from reset: source 0 first, then source 1.
    len0 = 16'd4;
    len1 = 16'd6;
    bpsk = 2'b11;
    do_packet("rr first", 2'b11, 0, 4, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0);
    do_packet("rr second", 2'b11, 1, 6, 1'b1, 16'd6, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pkt_tx_scheduler.md
# pkt_tx_scheduler

Transmit-side scheduler that sits in front of the MIX-mode packetizer and shares it between two payload sources. It arbitrates round-robin between requesters and streams the granted source's payload symbols into the packetizer input FIFO with the correct modulation flag and terminating tlast. It drives the packet's payload length, waits for the packetizer's `pkt_sent`, and enforces an idle gap so that packets never overlap in the FIFO.

## Interface
- `BYTES`, 1: symbol width in bytes on all AXIS ports.
- `GAP_CYCLES`, 16: idle cycles enforced after each packet (≥1).
- `SENT_TIMEOUT`, 65535: maximum cycles to wait for `pkt_sent` (16-bit counter).

- `clk`  in  1  slow symbol clock (1.024 MHz domain).
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  2  per-source packet request; level, sampled only in IDLE.
- `len0`, `len1`  in  16 each  payload length in bits; stable while `req[i]`=1.
- `bpsk`  in  2  per-source modulation (1=BPSK, 0=QPSK).
- `S0_tdata`/`S1_tdata`  in  BYTES*8  source symbol data.
- `S0_tvalid`/`S1_tvalid`  in  1  source valid.
- `S0_tready`/`S1_tready`  out  1  source ready.
- `M_tdata`  out  BYTES*8  to packetizer FIFO.
- `M_tvalid` out 1, `M_tready` in 1, `M_tlast` out 1, `M_tuser` out 1 (is_bpsk).
- `payload_length`  out  16  latched length of the current packet, in bits.
- `pkt_sent`  in  1  level from the packetizer.
- `gnt`  out  2  one-hot grant, registered.
- `done`  out  1  one-cycle pulse on normal completion.
- `err`  out  1  one-cycle pulse on rejection or timeout.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, WAIT_SENT, GAP.
- **IDLE.** If `req`≠0, select a source round-robin: the requester not granted last wins a tie, and the pointer resets to source 0.
  - Latch `payload_length`=len_sel and `is_bpsk`=bpsk_sel.
  - Symbol count: sym=len (BPSK) or len>>1 (QPSK, odd bit truncated).
  - If sym=0: pulse `err`, advance the pointer, stay in IDLE, no grant.
  - Otherwise set `gnt` and go to LOAD.
- **LOAD.** Combinational pass-through of the selected source:
  - `M_tvalid`=S_sel_tvalid; `S_sel_tready`=`M_tready`; `M_tdata`=S_sel_tdata; `M_tuser`=is_bpsk.
  - The unselected tready is 0.
  - A 16-bit counter increments on each M transfer.
  - `M_tlast`=1 when counter=sym-1.
  - On the last transfer, clear `gnt` and go to WAIT_SENT.
- **WAIT_SENT.** Wait for a rising edge of `pkt_sent` (registered previous value).
  - On the edge: pulse `done`, go to GAP.
  - If `SENT_TIMEOUT` cycles elapse first: pulse `err`, go to GAP.
- **GAP.** Count `GAP_CYCLES`, then go to IDLE. The pointer advances on GAP exit.
- `req` changes outside IDLE are ignored. Requesters must drop `req` on `done`/`err`, otherwise they are re-granted.
- `M_tvalid`, `M_tlast`, and both S tready are forced to 0 outside LOAD.

## Timing
- **Reset (async).** state=IDLE, `gnt`=0, `payload_length`=0, `done`=`err`=`busy`=0, pointer=0, counters=0. `M_tvalid`=`M_tlast`=0 immediately. Reset mid-LOAD truncates the packet without tlast; the downstream FIFO is flushed by the packetizer's WAIT state.
- `req` sampled at edge n → `gnt`/`busy` high after edge n. The first transfer can occur in that same cycle.
- Zero-bubble streaming: one symbol per cycle when S_sel_tvalid=`M_tready`=1.
- Backpressure on either side stalls the counter, and data/tlast hold.
- sym=1: the first transfer carries tlast.
- After the last transfer edge: `gnt`=0, and WAIT_SENT begins the next cycle.
- `done` pulses in the cycle after `pkt_sent` rises.
- IDLE is re-entered exactly `GAP_CYCLES` cycles after entering GAP.
- `pkt_sent` already high on entering WAIT_SENT does not count; a rising edge is required.

## Test plan
- Source 0 only, len0=8, BPSK, both valids/readies held high → `gnt`=01, 8 transfers, tlast on the 8th, `M_tuser`=1, `payload_length`=8; `pkt_sent` rise → `done` one cycle later; idle 16 cycles.
- Both `req`=11 from reset → source 0 first; source 1 is granted after GAP even if `req[0]` is reasserted (round-robin).
- Source 1, QPSK, len1=7 → sym=3 transfers, `M_tuser`=0, `payload_length`=7.
- len0=1 QPSK → `err` pulse, `gnt` stays 00, no M transfers, state remains IDLE; next `req[1]` is served.
- Random `M_tready` and `S_tvalid` gaps with len=20 BPSK → exactly 20 transfers, data order preserved, tlast only on the 20th.
- `pkt_sent` never rises (`SENT_TIMEOUT`=100) → `err` after 100 cycles, then GAP, then IDLE. Separately, `rst_n` low mid-LOAD → `M_tvalid`=0 and `gnt`=00 immediately.
